// File: rtl/harris_threshold_ctrl_if.sv
// Signal bundle between VGA timing / Harris detector and the threshold controller.
interface harris_threshold_ctrl_if #(
  parameter int FEAT_W = 18,
  parameter int CNT_W  = 16
);
  logic                     iVGA_BLANK_N;
  logic                     iVGA_VS;
  logic signed [FEAT_W-1:0] iFeature;
  logic                     iEnable;
  logic        [CNT_W-1:0]  iTarget;
  logic                     oClkEn;
  logic signed [FEAT_W-1:0] oThreshold;
  logic                     oCorner;
  logic        [CNT_W-1:0]  oCornerCount;
  logic                     oFrameDone;

  modport master (
    output iVGA_BLANK_N, iVGA_VS, iFeature, iEnable, iTarget,
    input  oClkEn, oThreshold, oCorner, oCornerCount, oFrameDone
  );

  modport slave (
    input  iVGA_BLANK_N, iVGA_VS, iFeature, iEnable, iTarget,
    output oClkEn, oThreshold, oCorner, oCornerCount, oFrameDone
  );
endinterface

// File: rtl/harris_threshold_ctrl.sv
// Per-frame Harris corner counter with adaptive threshold stepping at each
// vertical-sync falling edge.
module harris_threshold_ctrl #(
  parameter int FEAT_W      = 18,
  parameter int CNT_W       = 16,
  parameter int LATENCY     = 2,
  parameter int INIT_THRESH = 49152,
  parameter int STEP        = 1024,
  parameter int HYST        = 8,
  parameter int MIN_THRESH  = 1,
  parameter int MAX_THRESH  = 131071
) (
  input logic                   iCLK,
  input logic                   iRST_N,
  harris_threshold_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    WAIT_FRAME = 2'd0,
    ACTIVE     = 2'd1,
    UPDATE     = 2'd2
  } state_t;

  localparam logic signed [FEAT_W:0]   STEP_W = (FEAT_W+1)'(STEP);
  localparam logic signed [FEAT_W:0]   MIN_W  = (FEAT_W+1)'(MIN_THRESH);
  localparam logic signed [FEAT_W:0]   MAX_W  = (FEAT_W+1)'(MAX_THRESH);
  localparam logic signed [FEAT_W-1:0] INIT_W = FEAT_W'(INIT_THRESH);
  localparam logic        [CNT_W:0]    HYST_W = (CNT_W+1)'(HYST);

  state_t                   state, state_next;
  logic                     pixel_valid;
  logic                     vs_q;
  logic                     vs_fall;
  logic                     hit;
  logic                     corner;
  logic                     frame_done;
  logic        [CNT_W-1:0]  counter;
  logic        [CNT_W-1:0]  counter_inc;
  logic        [CNT_W-1:0]  count_q;
  logic signed [FEAT_W-1:0] threshold;
  logic signed [FEAT_W-1:0] thr_next;
  logic signed [FEAT_W:0]   thr_ext, thr_up, thr_dn;
  logic        [CNT_W:0]    cnt_ext, tgt_ext;
  logic                     go_up, go_down;

  assign bus.oClkEn       = bus.iVGA_BLANK_N;
  assign bus.oThreshold   = threshold;
  assign bus.oCorner      = corner;
  assign bus.oCornerCount = count_q;
  assign bus.oFrameDone   = frame_done;

  // Blank qualifier delayed to line up with the detector's feature pipeline.
  generate
    if (LATENCY == 0) begin : g_no_delay
      assign pixel_valid = bus.iVGA_BLANK_N;
    end else begin : g_delay
      localparam int unsigned LAT_U = LATENCY;
      logic [LATENCY-1:0] valid_dly;
      always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
          valid_dly <= '0;
        end else begin
          valid_dly[0] <= bus.iVGA_BLANK_N;
          for (int unsigned i = 1; i < LAT_U; i++) begin
            valid_dly[i] <= valid_dly[i-1];
          end
        end
      end
      assign pixel_valid = valid_dly[LATENCY-1];
    end
  endgenerate

  assign vs_fall     = vs_q && !bus.iVGA_VS;
  assign hit         = pixel_valid && (state != WAIT_FRAME) &&
                       ($signed(bus.iFeature) > threshold);
  assign counter_inc = (hit && !(&counter)) ? counter + CNT_W'(1) : counter;

  // Compare and step one bit wider than the operands so neither wraps.
  always_comb begin
    thr_ext  = {threshold[FEAT_W-1], threshold};
    thr_up   = thr_ext + STEP_W;
    thr_dn   = thr_ext - STEP_W;
    cnt_ext  = {1'b0, counter};
    tgt_ext  = {1'b0, bus.iTarget};
    go_up    = cnt_ext > (tgt_ext + HYST_W);
    go_down  = (cnt_ext + HYST_W) < tgt_ext;
    thr_next = threshold;
    if (bus.iEnable) begin
      if (go_up) begin
        thr_next = (thr_up > MAX_W) ? MAX_W[FEAT_W-1:0] : thr_up[FEAT_W-1:0];
      end else if (go_down) begin
        thr_next = (thr_dn < MIN_W) ? MIN_W[FEAT_W-1:0] : thr_dn[FEAT_W-1:0];
      end
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state <= WAIT_FRAME;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      WAIT_FRAME: if (vs_fall) state_next = ACTIVE;
      ACTIVE:     if (vs_fall) state_next = UPDATE;
      UPDATE:     state_next = ACTIVE;
      default:    state_next = WAIT_FRAME;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      vs_q       <= 1'b1;
      corner     <= 1'b0;
      frame_done <= 1'b0;
      counter    <= '0;
      count_q    <= '0;
      threshold  <= INIT_W;
    end else begin
      vs_q       <= bus.iVGA_VS;
      corner     <= hit;
      frame_done <= (state == UPDATE);
      case (state)
        WAIT_FRAME: if (vs_fall) counter <= '0;
        ACTIVE:     counter <= counter_inc;
        UPDATE: begin
          // A hit in the close-out cycle already belongs to the next frame.
          count_q   <= counter;
          counter   <= CNT_W'(hit);
          threshold <= thr_next;
        end
        default:    counter <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_harris_threshold_ctrl.sv
// Directed bench for harris_threshold_ctrl: per-frame vectors plus latency,
// frame-boundary, reset, clamp and saturation sequences.
module tb_harris_threshold_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  harris_threshold_ctrl_if bus_m ();
  harris_threshold_ctrl_if bus_lo ();
  harris_threshold_ctrl_if bus_hi ();

  harris_threshold_ctrl dut (.iCLK(clk), .iRST_N(rst_n), .bus(bus_m));
  harris_threshold_ctrl #(.INIT_THRESH(1500))   dut_lo (.iCLK(clk), .iRST_N(rst_n), .bus(bus_lo));
  harris_threshold_ctrl #(.INIT_THRESH(130500)) dut_hi (.iCLK(clk), .iRST_N(rst_n), .bus(bus_hi));

  int n_checks = 0;
  int n_fail   = 0;
  int fd_cnt   = 0;
  int fd0;

  always @(negedge clk) if (bus_m.oFrameDone) fd_cnt++;

  typedef struct {
    int   npx;
    int   feat;
    logic en;
    int   tgt;
    int   exp_cnt;
    int   exp_thr;
  } vec_t;
  vec_t vecs [15];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic b, input logic v, input int n);
    bus_m.iVGA_BLANK_N  = b;  bus_m.iVGA_VS  = v;
    bus_lo.iVGA_BLANK_N = b;  bus_lo.iVGA_VS = v;
    bus_hi.iVGA_BLANK_N = b;  bus_hi.iVGA_VS = v;
    repeat (n) tick();
  endtask

  task automatic close_frame();
    drive(1'b0, 1'b1, 3);
    drive(1'b0, 1'b0, 3);
    drive(1'b0, 1'b1, 2);
  endtask

  task automatic frame(input int n);
    drive(1'b1, 1'b1, n);
    close_frame();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0]  = '{37, 60000, 1'b0, 20,    37, 49152};
    vecs[1]  = '{37, 60000, 1'b0, 20,    37, 49152};
    vecs[2]  = '{37, 60000, 1'b1, 20,    37, 50176};
    vecs[3]  = '{37, 60000, 1'b1, 20,    37, 51200};
    vecs[4]  = '{28, 60000, 1'b1, 20,    28, 51200};
    vecs[5]  = '{29, 60000, 1'b1, 20,    29, 52224};
    vecs[6]  = '{12, 60000, 1'b1, 20,    12, 52224};
    vecs[7]  = '{11, 60000, 1'b1, 20,    11, 51200};
    vecs[8]  = '{0,  0,     1'b0, 20,    0,  51200};
    vecs[9]  = '{5,  51000, 1'b1, 20,    0,  50176};
    vecs[10] = '{5,  50176, 1'b1, 20,    0,  49152};
    vecs[11] = '{5,  49153, 1'b1, 20,    5,  48128};
    vecs[12] = '{4,  -5,    1'b0, 20,    0,  48128};
    vecs[13] = '{30, 60000, 1'b1, 65535, 30, 47104};
    vecs[14] = '{30, 60000, 1'b0, 0,     30, 47104};

    rst_n = 1'b0;
    bus_m.iFeature  = '0;      bus_m.iEnable  = 1'b0; bus_m.iTarget  = '0;
    bus_lo.iFeature = '0;      bus_lo.iEnable = 1'b0; bus_lo.iTarget = 16'd500;
    bus_hi.iFeature = 18'sd131000; bus_hi.iEnable = 1'b0; bus_hi.iTarget = '0;
    drive(1'b0, 1'b1, 3);
    chk("reset_thr",        int'(bus_m.oThreshold), 49152);
    chk("reset_count",      int'(bus_m.oCornerCount), 0);
    chk("reset_corner",     int'(bus_m.oCorner), 0);
    chk("reset_frame_done", int'(bus_m.oFrameDone), 0);
    chk("reset_thr_lo",     int'(bus_lo.oThreshold), 1500);
    chk("reset_thr_hi",     int'(bus_hi.oThreshold), 130500);
    rst_n = 1'b1;

    // First frame after reset is partial and must be discarded.
    bus_m.iFeature = 18'sd60000;
    frame(37);
    chk("discard_frame_done", fd_cnt, 0);
    chk("discard_count", int'(bus_m.oCornerCount), 0);

    for (int i = 0; i < 15; i++) begin
      bus_m.iFeature = FEAT_CAST(vecs[i].feat);
      bus_m.iEnable  = vecs[i].en;
      bus_m.iTarget  = 16'(vecs[i].tgt);
      fd0 = fd_cnt;
      frame(vecs[i].npx);
      chk($sformatf("vec%0d_count", i), int'(bus_m.oCornerCount), vecs[i].exp_cnt);
      chk($sformatf("vec%0d_thr", i),   int'(bus_m.oThreshold),   vecs[i].exp_thr);
      chk($sformatf("vec%0d_done", i),  fd_cnt - fd0, 1);
    end

    // Reset in the middle of a frame.
    bus_m.iEnable  = 1'b0;
    bus_m.iFeature = 18'sd60000;
    drive(1'b1, 1'b1, 10);
    chk("pre_reset_corner", int'(bus_m.oCorner), 1);
    rst_n = 1'b0;
    #1;
    chk("midreset_thr",    int'(bus_m.oThreshold), 49152);
    chk("midreset_count",  int'(bus_m.oCornerCount), 0);
    chk("midreset_corner", int'(bus_m.oCorner), 0);
    tick();
    rst_n = 1'b1;
    fd0 = fd_cnt;
    frame(10);
    chk("post_reset_discard", fd_cnt - fd0, 0);
    frame(7);
    chk("post_reset_count", int'(bus_m.oCornerCount), 7);
    chk("post_reset_done",  fd_cnt - fd0, 1);
    chk("post_reset_thr",   int'(bus_m.oThreshold), 49152);

    // Feature two cycles after the last active pixel lines up with it.
    bus_m.iFeature = '0;
    drive(1'b1, 1'b1, 1);
    chk("clk_en_high", int'(bus_m.oClkEn), 1);
    drive(1'b0, 1'b1, 1);
    chk("clk_en_low", int'(bus_m.oClkEn), 0);
    bus_m.iFeature = 18'sd60000;
    drive(1'b0, 1'b1, 1);
    chk("lat2_corner", int'(bus_m.oCorner), 1);
    bus_m.iFeature = '0;
    drive(1'b0, 1'b1, 1);
    chk("lat2_corner_end", int'(bus_m.oCorner), 0);
    close_frame();
    chk("lat2_count", int'(bus_m.oCornerCount), 1);

    drive(1'b1, 1'b1, 1);
    drive(1'b0, 1'b1, 2);
    bus_m.iFeature = 18'sd60000;
    drive(1'b0, 1'b1, 1);
    chk("lat3_corner", int'(bus_m.oCorner), 0);
    bus_m.iFeature = '0;
    drive(1'b0, 1'b1, 1);
    close_frame();
    chk("lat3_count", int'(bus_m.oCornerCount), 0);

    // Frame-boundary ownership of hits.
    bus_m.iFeature = 18'sd60000;
    drive(1'b1, 1'b1, 4);
    drive(1'b0, 1'b1, 1);
    drive(1'b0, 1'b0, 3);
    drive(1'b0, 1'b1, 2);
    chk("vsfall_hit_count", int'(bus_m.oCornerCount), 4);
    drive(1'b1, 1'b1, 5);
    drive(1'b0, 1'b0, 3);
    drive(1'b0, 1'b1, 2);
    chk("update_hit_close", int'(bus_m.oCornerCount), 4);
    frame(2);
    chk("update_hit_next", int'(bus_m.oCornerCount), 3);

    // Clamp behaviour on the low/high threshold instances.
    bus_lo.iEnable = 1'b1;
    bus_hi.iEnable = 1'b1;
    frame(20);
    chk("lo_thr_f1", int'(bus_lo.oThreshold), 476);
    chk("hi_thr_f1", int'(bus_hi.oThreshold), 131071);
    chk("hi_cnt_f1", int'(bus_hi.oCornerCount), 20);
    frame(20);
    chk("lo_thr_f2", int'(bus_lo.oThreshold), 1);
    chk("hi_thr_f2", int'(bus_hi.oThreshold), 131071);
    chk("hi_cnt_f2", int'(bus_hi.oCornerCount), 0);
    frame(20);
    chk("lo_thr_f3", int'(bus_lo.oThreshold), 1);
    bus_lo.iEnable = 1'b0;
    bus_hi.iEnable = 1'b0;

    // Counter saturation.
    bus_m.iFeature = 18'sd60000;
    frame(70000);
    chk("sat_count", int'(bus_m.oCornerCount), 65535);
    frame(3);
    chk("after_sat_count", int'(bus_m.oCornerCount), 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  function automatic logic signed [17:0] FEAT_CAST(input int v);
    return 18'(v);
  endfunction

endmodule
